// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and vector addresses for the interrupt sequencer.
// Latency: none (types only); backpressure: n/a.
package int_pkg;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'b00,
    KIND_IRQ   = 2'b01,
    KIND_NMI   = 2'b10,
    KIND_RESET = 2'b11
  } int_kind_t;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'b00,
    ST_IDLE     = 2'b01,
    ST_SERVICE  = 2'b10
  } state_t;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  function automatic logic [15:0] kind_vector(input int_kind_t kind);
    case (kind)
      KIND_NMI:   kind_vector = VEC_NMI;
      KIND_RESET: kind_vector = VEC_RST;
      default:    kind_vector = VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Decoder <-> sequencer handshake bundle; master is the decoder, slave the sequencer.
// Latency: wires only; backpressure: sequencer holds its request until int_ack.
interface interrupt_sequencer_if;
  import int_pkg::*;

  logic        insn_boundary;
  logic        brk_req;
  logic        vec_fetch;
  logic        int_ack;
  logic        int_take;
  int_kind_t   int_kind;
  logic [15:0] int_vector;
  logic        set_b;

  modport master (
    output insn_boundary, brk_req, vec_fetch, int_ack,
    input  int_take, int_kind, int_vector, set_b
  );

  modport slave (
    input  insn_boundary, brk_req, vec_fetch, int_ack,
    output int_take, int_kind, int_vector, set_b
  );

endinterface

// File: rtl/interrupt_sequencer_pin_sync.sv
// Two-flop synchroniser for asynchronous pins, synchronous active-low reset to RST_VAL.
// Latency: 2 cycles; backpressure: none, samples every cycle.
module pin_sync #(
  parameter int unsigned      W       = 1,
  parameter logic [W-1:0]     RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt/reset sequencer: picks RESET > NMI > BRK > IRQ at instruction boundaries.
// Latency: int_take combinational, kind/vector/set_b registered next cycle; RDY=0 freezes sequencing.
// Optional INT_NMI_HIJACK_EN lets a pending NMI redirect an IRQ/BRK sequence before its vector fetch.
module interrupt_sequencer
  import int_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   NMI,
  input  logic                   IRQ,
  input  logic                   RDY,
  input  logic                   i_flag,
  interrupt_sequencer_if.slave   dec
);

  logic [1:0]  pins_s;
  logic        nmi_s, irq_s;

  state_t      state_q, state_d;
  int_kind_t   kind_q, kind_d;
  logic [15:0] vector_q, vector_d;
  logic        set_b_q, set_b_d;
  logic        nmi_pending_q, nmi_pending_d;
  logic        brk_pending_q, brk_pending_d;
  logic        nmi_s_q, nmi_s_d;
  logic        fetched_q, fetched_d;

  logic        take;
  logic        nmi_rise, irq_ok, clr_nmi, clr_brk, set_brk;
  int_kind_t   sel;

  pin_sync #(.W(2), .RST_VAL(2'b11)) u_pin_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     ({NMI, IRQ}),
    .q     (pins_s)
  );

  assign nmi_s = ~pins_s[1];
  assign irq_s = ~pins_s[0];

  function automatic int_kind_t select_kind(input logic nmi, input logic brk, input logic irq);
    if (nmi)             select_kind = KIND_NMI;
    else if (brk || irq) select_kind = KIND_IRQ;
    else                 select_kind = KIND_NONE;
  endfunction

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    vector_d  = vector_q;
    set_b_d   = set_b_q;
    fetched_d = fetched_q;
    nmi_s_d   = nmi_s;
    take      = 1'b0;
    clr_nmi   = 1'b0;
    clr_brk   = 1'b0;
    nmi_rise  = nmi_s & ~nmi_s_q;
    irq_ok    = irq_s & ~i_flag;
    set_brk   = RDY & dec.brk_req;
    sel       = select_kind(nmi_pending_q, brk_pending_q, irq_ok);

    if (RDY) begin
      case (state_q)
        ST_RST_HOLD: begin
          take      = 1'b1;
          state_d   = ST_SERVICE;
          kind_d    = KIND_RESET;
          vector_d  = VEC_RST;
          set_b_d   = 1'b0;
          fetched_d = 1'b0;
        end
        ST_IDLE: begin
          if (dec.insn_boundary && sel != KIND_NONE) begin
            take      = 1'b1;
            state_d   = ST_SERVICE;
            kind_d    = sel;
            vector_d  = kind_vector(sel);
            set_b_d   = (sel == KIND_IRQ) && brk_pending_q;
            fetched_d = 1'b0;
          end
        end
        ST_SERVICE: begin
          if (dec.vec_fetch) fetched_d = 1'b1;
`ifdef INT_NMI_HIJACK_EN
          // set_b is left alone so a hijacked BRK still pushes B=1
          if (kind_q == KIND_IRQ && nmi_pending_q && !fetched_q) begin
            kind_d   = KIND_NMI;
            vector_d = VEC_NMI;
          end
`endif
          if (dec.int_ack) begin
            state_d = ST_IDLE;
            clr_nmi = (kind_d == KIND_NMI);
            clr_brk = set_b_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // a fresh edge must survive an acknowledge landing in the same cycle
    nmi_pending_d = nmi_rise | (nmi_pending_q & ~clr_nmi);
    brk_pending_d = set_brk  | (brk_pending_q & ~clr_brk);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= ST_RST_HOLD;
      kind_q        <= KIND_RESET;
      vector_q      <= VEC_RST;
      set_b_q       <= 1'b0;
      nmi_pending_q <= 1'b0;
      brk_pending_q <= 1'b0;
      nmi_s_q       <= 1'b0;
      fetched_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      vector_q      <= vector_d;
      set_b_q       <= set_b_d;
      nmi_pending_q <= nmi_pending_d;
      brk_pending_q <= brk_pending_d;
      nmi_s_q       <= nmi_s_d;
      fetched_q     <= fetched_d;
    end
  end

  assign dec.int_take   = take & RST_N;
  assign dec.int_kind   = kind_q;
  assign dec.int_vector = vector_q;
  assign dec.set_b      = set_b_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: reset, NMI edge, IRQ masking, BRK, hijack, RDY, mid-sequence reset.
module tb_interrupt_sequencer;
  import int_pkg::*;

  logic CLK, RST_N, NMI, IRQ, RDY, i_flag;
  int   n_tests = 0;
  int   n_fail  = 0;

  interrupt_sequencer_if dec_if ();

  interrupt_sequencer dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .NMI    (NMI),
    .IRQ    (IRQ),
    .RDY    (RDY),
    .i_flag (i_flag),
    .dec    (dec_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] kind, input logic [15:0] vec,
                           input logic setb);
    check({tag, "_kind"}, {30'd0, dec_if.int_kind}, {30'd0, kind});
    check({tag, "_vec"},  {16'd0, dec_if.int_vector}, {16'd0, vec});
    check({tag, "_setb"}, {31'd0, dec_if.set_b}, {31'd0, setb});
  endtask

  task automatic ack();
    dec_if.int_ack = 1'b1;
    tick();
    dec_if.int_ack = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; NMI = 1'b1; IRQ = 1'b1; RDY = 1'b1; i_flag = 1'b1;
    dec_if.insn_boundary = 1'b0; dec_if.brk_req = 1'b0;
    dec_if.vec_fetch = 1'b0; dec_if.int_ack = 1'b0;
    tick(); tick(); tick();

    // reset state and release
    check("rst_take", {31'd0, dec_if.int_take}, 32'd0);
    check_out("rst", 2'b11, 16'hFFFC, 1'b0);
    RST_N = 1'b1; #1;
    check("rel_take", {31'd0, dec_if.int_take}, 32'd1);
    tick();
    check("rel_svc_take", {31'd0, dec_if.int_take}, 32'd0);
    check_out("rel", 2'b11, 16'hFFFC, 1'b0);
    ack();
    dec_if.insn_boundary = 1'b1; #1;
    check("idle_noreq", {31'd0, dec_if.int_take}, 32'd0);
    tick();
    dec_if.insn_boundary = 1'b0;

    // NMI falling edge: pending three cycles after the pin falls
    NMI = 1'b0;
    tick(); tick();
    dec_if.insn_boundary = 1'b1; #1;
    check("nmi_early", {31'd0, dec_if.int_take}, 32'd0);
    tick();
    check("nmi_take", {31'd0, dec_if.int_take}, 32'd1);
    tick();
    dec_if.insn_boundary = 1'b0; #1;
    check("nmi_svc_take", {31'd0, dec_if.int_take}, 32'd0);
    check_out("nmi", 2'b10, 16'hFFFA, 1'b0);
    dec_if.vec_fetch = 1'b1; tick(); dec_if.vec_fetch = 1'b0;
    ack();
    dec_if.insn_boundary = 1'b1; #1;
    check("nmi_held1", {31'd0, dec_if.int_take}, 32'd0);
    tick();
    check("nmi_held2", {31'd0, dec_if.int_take}, 32'd0);
    tick();
    dec_if.insn_boundary = 1'b0;

    // IRQ masking by the I flag
    NMI = 1'b1; IRQ = 1'b0;
    tick(); tick();
    dec_if.insn_boundary = 1'b1; #1;
    check("irq_masked", {31'd0, dec_if.int_take}, 32'd0);
    tick();
    i_flag = 1'b0; #1;
    check("irq_take", {31'd0, dec_if.int_take}, 32'd1);
    tick();
    dec_if.insn_boundary = 1'b0; #1;
    check_out("irq", 2'b01, 16'hFFFE, 1'b0);
    ack();

    // BRK with IRQ also asserted: BRK first, IRQ at the following boundary
    dec_if.brk_req = 1'b1; tick(); dec_if.brk_req = 1'b0;
    dec_if.insn_boundary = 1'b1; #1;
    check("brk_take", {31'd0, dec_if.int_take}, 32'd1);
    tick();
    dec_if.insn_boundary = 1'b0; #1;
    check_out("brk", 2'b01, 16'hFFFE, 1'b1);
    ack();
    dec_if.insn_boundary = 1'b1; #1;
    check("brk_irq_take", {31'd0, dec_if.int_take}, 32'd1);
    tick();
    dec_if.insn_boundary = 1'b0; #1;
    check_out("brk_irq", 2'b01, 16'hFFFE, 1'b0);
    ack();
    IRQ = 1'b1; i_flag = 1'b1;
    tick(); tick();

    // NMI edge arriving during a BRK sequence, before the vector fetch
    dec_if.brk_req = 1'b1; tick(); dec_if.brk_req = 1'b0;
    dec_if.insn_boundary = 1'b1; tick(); dec_if.insn_boundary = 1'b0;
    NMI = 1'b0;
    tick(); tick(); tick(); tick();
    dec_if.vec_fetch = 1'b1; tick(); dec_if.vec_fetch = 1'b0;
`ifdef INT_NMI_HIJACK_EN
    check_out("hijack", 2'b10, 16'hFFFA, 1'b1);
    ack();
    dec_if.insn_boundary = 1'b1; #1;
    check("hijack_consumed", {31'd0, dec_if.int_take}, 32'd0);
    tick();
    dec_if.insn_boundary = 1'b0;
`else
    check_out("nohijack", 2'b01, 16'hFFFE, 1'b1);
    ack();
    dec_if.insn_boundary = 1'b1; #1;
    check("nohijack_nmi_take", {31'd0, dec_if.int_take}, 32'd1);
    tick();
    dec_if.insn_boundary = 1'b0; #1;
    check_out("nohijack_nmi", 2'b10, 16'hFFFA, 1'b0);
    ack();
`endif

    // RDY=0 freezes sequencing with NMI pending
    NMI = 1'b1; tick(); tick(); tick();
    NMI = 1'b0; tick(); tick(); tick();
    RDY = 1'b0; dec_if.insn_boundary = 1'b1; #1;
    check("rdy_low_take", {31'd0, dec_if.int_take}, 32'd0);
    tick();
    check("rdy_low_hold", {31'd0, dec_if.int_take}, 32'd0);
    RDY = 1'b1; #1;
    check("rdy_high_take", {31'd0, dec_if.int_take}, 32'd1);
    tick();
    dec_if.insn_boundary = 1'b0; #1;
    check_out("rdy", 2'b10, 16'hFFFA, 1'b0);

    // reset in SERVICE with BRK and NMI pending clears both
    dec_if.brk_req = 1'b1; tick(); dec_if.brk_req = 1'b0;
    NMI = 1'b1; tick(); tick(); tick();
    NMI = 1'b0; tick(); tick(); tick();
    NMI = 1'b1; tick();
    RST_N = 1'b0; #1;
    check("mid_rst_take", {31'd0, dec_if.int_take}, 32'd0);
    tick();
    check_out("mid_rst", 2'b11, 16'hFFFC, 1'b0);
    RST_N = 1'b1; #1;
    check("mid_rel_take", {31'd0, dec_if.int_take}, 32'd1);
    tick();
    ack();
    dec_if.insn_boundary = 1'b1; #1;
    check("pending_cleared", {31'd0, dec_if.int_take}, 32'd0);
    tick();
    dec_if.insn_boundary = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
